// File: rtl/bcd_sched_pkg.sv
// Shared types, constants and elaboration helpers for the BCD conversion scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  // Smallest number of decimal digits able to hold 2**w - 1.
  function automatic int unsigned min_digits(input int unsigned w);
    longint unsigned maxv;
    int unsigned     d;
    maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (maxv != 0) begin
        d    = d + 1;
        maxv = maxv / 64'd10;
      end
    end
    return d;
  endfunction

  // Width of an index into n items, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// Requester-side bus of the shared BCD converter: requests in, digits and acks out.
interface bcd_convert_scheduler_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned W      = 12,
  parameter int unsigned DIGITS = 4
);
  import bcd_sched_pkg::*;

  localparam int unsigned GW = id_width(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*W-1:0]          bin_in;
  logic [N_REQ-1:0]            ack;
  logic                        valid_out;
  logic [GW-1:0]               grant_id;
  logic [DIGITS*DIGIT_W-1:0]   bcd_out;
  logic                        busy;

  // Requesters drive req/bin_in and observe the results.
  modport master (
    output req, bin_in,
    input  ack, valid_out, grant_id, bcd_out, busy
  );

  // The scheduler consumes requests and returns results.
  modport slave (
    input  req, bin_in,
    output ack, valid_out, grant_id, bcd_out, busy
  );

endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every digit nibble >= 5, then shift left by one.
module bcd_dd_step
  import bcd_sched_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic [W+DIGITS*DIGIT_W-1:0] din,
  output logic [W+DIGITS*DIGIT_W-1:0] dout
);

  localparam int unsigned SRW = W + DIGITS * DIGIT_W;

  logic [SRW-1:0] adj;

  // Binary field passes through untouched; only digit nibbles are corrected.
  assign adj[W-1:0] = din[W-1:0];

  // Per-digit add-3 correction, wrapping inside the nibble with no carry out.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign adj[W + d*DIGIT_W +: DIGIT_W] =
      (din[W + d*DIGIT_W +: DIGIT_W] >= ADD3_THRESH) ?
        din[W + d*DIGIT_W +: DIGIT_W] + 4'd3 :
        din[W + d*DIGIT_W +: DIGIT_W];
  end

  assign dout = {adj[SRW-2:0], 1'b0};

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shared sequential binary-to-BCD engine serving N_REQ requesters in round-robin order.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned W      = 12,
  parameter int unsigned DIGITS = 4
) (
  input logic                   clk,
  input logic                   reset,
  bcd_convert_scheduler_if.slave bus
);

  localparam int unsigned BW  = DIGITS * DIGIT_W;
  localparam int unsigned SRW = W + BW;
  localparam int unsigned GW  = id_width(N_REQ);
  localparam int unsigned CW  = id_width(W);

  if (N_REQ < 1 || N_REQ > 8) begin : g_nreq_chk
    $error("bcd_convert_scheduler: N_REQ must be in 1..8");
  end
  if (DIGITS < min_digits(W)) begin : g_digits_chk
    $error("bcd_convert_scheduler: DIGITS too small to hold 2**W-1");
  end

  state_e           state_q;
  logic [GW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [SRW-1:0]   sr_q;
  logic [GW-1:0]    grant_q;
  logic [BW-1:0]    bcd_q;
  logic [N_REQ-1:0] ack_q;
  logic             valid_q;
  logic             busy_q;

  logic [GW-1:0]    pick_d;
  logic             any_req_d;
  logic [W-1:0]     cap_val_d;
  logic [SRW-1:0]   step_d;
  logic [GW-1:0]    ptr_nxt_d;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    logic [N_REQ-1:0] req_sh;
    int unsigned      idx;
    pick_d    = '0;
    any_req_d = 1'b0;
    req_sh    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx    = (32'(ptr_q) + i) % N_REQ;
      req_sh = bus.req >> idx;
      if (!any_req_d && req_sh[0]) begin
        any_req_d = 1'b1;
        pick_d    = GW'(idx);
      end
    end
  end

  // Operand of the requester that would be granted this cycle.
  always_comb begin
    cap_val_d = W'(bus.bin_in >> (32'(pick_d) * W));
  end

  // Pointer advance past the requester just served.
  always_comb begin
    ptr_nxt_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  bcd_dd_step #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_step (
    .din  (sr_q),
    .dout (step_d)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      grant_q <= '0;
      bcd_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            grant_q <= pick_d;
            sr_q    <= {{BW{1'b0}}, cap_val_d};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= step_d;
          cnt_q <= cnt_q + 1'b1;
          // Digits are taken straight from the final step output so the
          // result appears on the same edge that performs step W.
          if (cnt_q == CW'(W - 1)) begin
            bcd_q   <= step_d[W +: BW];
            valid_q <= 1'b1;
            ack_q   <= N_REQ'(1) << grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ptr_nxt_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Bench for bcd_convert_scheduler: transaction-level model, per-cycle compare, directed and random stimulus.
module tb_bcd_convert_scheduler;
  import bcd_sched_pkg::*;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned W      = 12;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned BW     = DIGITS * 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_convert_scheduler_if #(.N_REQ(N_REQ), .W(W), .DIGITS(DIGITS)) bus ();

  bcd_convert_scheduler #(.N_REQ(N_REQ), .W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  bit chk_en     = 1'b0;

  // Decimal digits of v, ones digit in the low nibble.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Transaction model: a capture at edge c completes at c+W and frees the engine at c+W+2.
  int               m_done = -100;
  int               m_free = 0;
  int unsigned      m_ptr  = 0;
  int unsigned      m_gid  = 0;
  int unsigned      m_val  = 0;
  logic [BW-1:0]    m_bcd  = '0;
  bit               e_valid, e_busy;
  logic [N_REQ-1:0] e_ack;
  logic [BW-1:0]    e_bcd;
  int unsigned      e_gid;

  always @(posedge clk) begin
    bit          found;
    int unsigned c;
    cyc = cyc + 1;
    if (reset) begin
      m_ptr  = 0;
      m_gid  = 0;
      m_bcd  = '0;
      m_done = -100;
      m_free = cyc + 1;
    end else begin
      if (cyc >= m_free && bus.req != '0) begin
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
          c = (m_ptr + i) % N_REQ;
          if (!found && bus.req[c]) begin
            found = 1'b1;
            m_gid = c;
          end
        end
        m_val  = bus.bin_in[m_gid*W +: W];
        m_done = cyc + W;
        m_free = cyc + W + 2;
      end
      if (cyc == m_done) m_bcd = to_bcd(m_val);
      if (cyc == m_done + 1) m_ptr = (m_gid + 1) % N_REQ;
    end
    e_valid = !reset && (cyc == m_done);
    e_busy  = !reset && (cyc >= m_done - W) && (cyc <= m_done);
    e_ack   = e_valid ? (N_REQ'(1) << m_gid) : '0;
    e_bcd   = m_bcd;
    e_gid   = m_gid;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors = vectors + 1;
      if (bus.valid_out !== e_valid) begin
        miscompares = miscompares + 1;
        $display("FAIL cyc %0d valid_out got %b want %b", cyc, bus.valid_out, e_valid);
      end
      if (bus.busy !== e_busy) begin
        miscompares = miscompares + 1;
        $display("FAIL cyc %0d busy got %b want %b", cyc, bus.busy, e_busy);
      end
      if (bus.ack !== e_ack) begin
        miscompares = miscompares + 1;
        $display("FAIL cyc %0d ack got %b want %b", cyc, bus.ack, e_ack);
      end
      if (bus.bcd_out !== e_bcd) begin
        miscompares = miscompares + 1;
        $display("FAIL cyc %0d bcd_out got %h want %h", cyc, bus.bcd_out, e_bcd);
      end
      if (bus.grant_id !== 1'(e_gid)) begin
        miscompares = miscompares + 1;
        $display("FAIL cyc %0d grant_id got %0d want %0d", cyc, bus.grant_id, e_gid);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors = vectors + 1;
    if (got !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL valid_timeout got none want pulse within 60 cycles");
    end
  endtask

  // Returns at the capture edge (rising busy).
  task automatic wait_capture(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = bus.busy;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy === 1'b1 && prev !== 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = bus.busy;
    end
    if (!ok) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL capture_timeout got none want busy rise within 40 cycles");
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic convert(input int unsigned id, input logic [W-1:0] v,
                         input logic [BW-1:0] want, input string nm, output int cap);
    bit ok;
    bus.bin_in[id*W +: W] = v;
    bus.req[id] = 1'b1;
    wait_capture(ok);
    cap = cyc;
    if (ok) begin
      wait_valid(ok);
      if (ok) begin
        check_lit({nm, "_bcd"}, 32'(bus.bcd_out), 32'(want));
        check_lit({nm, "_latency"}, 32'(cyc - cap), 32'(W));
        check_lit({nm, "_ack"}, 32'(bus.ack), 32'(1 << id));
        check_lit({nm, "_grant"}, 32'(bus.grant_id), 32'(id));
      end
    end
    bus.req[id] = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 12'd0;
      1:       return 12'd4095;
      2:       return 12'd999;
      3:       return 12'd1000;
      default: return W'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    bit            ok;
    bit            bad;
    int            cap0, cap1, cap2;
    logic [BW-1:0] rr_bcd  [3];
    int unsigned   rr_gid  [3];

    reset      = 1'b1;
    bus.req    = '0;
    bus.bin_in = '0;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    check_lit("reset_valid", 32'(bus.valid_out), 32'd0);
    check_lit("reset_busy",  32'(bus.busy),      32'd0);
    check_lit("reset_bcd",   32'(bus.bcd_out),   32'd0);
    check_lit("reset_grant", 32'(bus.grant_id),  32'd0);
    check_lit("reset_ack",   32'(bus.ack),       32'd0);

    // Full-scale value on requester 0; busy drops the cycle after the pulse.
    convert(0, 12'd4095, 16'h4095, "max4095", cap0);
    tick();
    check_lit("max4095_busy_fall", 32'(bus.busy), 32'd0);
    check_lit("max4095_valid_fall", 32'(bus.valid_out), 32'd0);

    // Back-to-back single conversions.
    convert(0, 12'd0,    16'h0000, "seq0",    cap0);
    convert(0, 12'd1000, 16'h1000, "seq1000", cap1);
    convert(0, 12'd9,    16'h0009, "seq9",    cap2);
    check_lit("spacing_a", 32'(cap1 - cap0 >= W + 2), 32'd1);
    check_lit("spacing_b", 32'(cap2 - cap1 >= W + 2), 32'd1);

    // Both requesters held: strict alternation from requester 0.
    apply_reset();
    bus.bin_in[0*W +: W] = 12'd123;
    bus.bin_in[1*W +: W] = 12'd3210;
    bus.req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_valid(ok);
      rr_bcd[j] = ok ? bus.bcd_out : '1;
      rr_gid[j] = ok ? 32'(bus.grant_id) : 32'd7;
      if (ok) check_lit("rr_ack", 32'(bus.ack), 32'(1 << rr_gid[j]));
    end
    bus.req = 2'b00;
    check_lit("rr_grant0", rr_gid[0], 32'd0);
    check_lit("rr_grant1", rr_gid[1], 32'd1);
    check_lit("rr_grant2", rr_gid[2], 32'd0);
    check_lit("rr_bcd0", 32'(rr_bcd[0]), 32'h0123);
    check_lit("rr_bcd1", 32'(rr_bcd[1]), 32'h3210);
    check_lit("rr_bcd2", 32'(rr_bcd[2]), 32'h0123);

    // Operand changed after capture must not affect the result.
    bus.bin_in[0*W +: W] = 12'd255;
    bus.req[0] = 1'b1;
    wait_capture(ok);
    tick();
    tick();
    bus.bin_in[0*W +: W] = 12'd77;
    wait_valid(ok);
    if (ok) check_lit("late_change_bcd", 32'(bus.bcd_out), 32'h0255);
    bus.req[0] = 1'b0;

    // Reset in mid-conversion (pointer is 1, so requester 1 is captured first).
    bus.bin_in[0*W +: W] = 12'd321;
    bus.bin_in[1*W +: W] = 12'd654;
    bus.req = 2'b11;
    wait_capture(ok);
    check_lit("abort_grant_before", 32'(bus.grant_id), 32'd1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_lit("abort_valid", 32'(bus.valid_out), 32'd0);
    check_lit("abort_ack",   32'(bus.ack),       32'd0);
    check_lit("abort_busy",  32'(bus.busy),      32'd0);
    check_lit("abort_bcd",   32'(bus.bcd_out),   32'd0);
    check_lit("abort_grant", 32'(bus.grant_id),  32'd0);
    wait_valid(ok);
    if (ok) begin
      check_lit("restart_grant", 32'(bus.grant_id), 32'd0);
      check_lit("restart_bcd",   32'(bus.bcd_out),  32'h0321);
    end
    bus.req = 2'b00;
    repeat (4) tick();

    // Random requesters following the handshake, with operand churn.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.bin_in[i*W +: W] = pick_val();
          bus.req[i] = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          bus.bin_in[i*W +: W] = pick_val();
        end else if (bus.req[i] && $urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (20) tick();

    // Exhaustive sweep through requester 1.
    for (int v = 0; v < 4096; v++) begin
      bus.bin_in[1*W +: W] = W'(v);
      bus.req = 2'b10;
      wait_valid(ok);
      bus.req = 2'b00;
      if (!ok) break;
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
        if (bus.bcd_out[d*4 +: 4] > 4'd9) bad = 1'b1;
      end
      check_lit("sweep_digit_range", 32'(bad), 32'd0);
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
